// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule with registered round-key read port
module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         enc_or_dec_i,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         keys_valid_o
);

    typedef enum logic {IDLE, EXPAND} state_t;

    // Forward AES S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state, state_n;
    logic [3:0]     cnt, cnt_n;
    logic           busy_n, done_n, keys_valid_n;
    logic           wr_en;
    logic [3:0]     wr_idx;
    logic [127:0]   wr_data;
    logic [127:0]   prev_key;
    logic [31:0]    rot, t_word, n0, n1, n2, n3;
    logic [3:0]     rd_e;
    logic [127:0]   rk_tab [0:NUM_ROUNDS];

    // One round of the key schedule, computed from the previously written entry.
    always_comb begin
        prev_key = (cnt == 4'd0) ? 128'h0 : rk_tab[cnt - 4'd1];
        rot      = {prev_key[23:0], prev_key[31:24]};
        t_word   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                   ^ {rcon(cnt), 24'h0};
        n0       = prev_key[127:96] ^ t_word;
        n1       = prev_key[95:64]  ^ n0;
        n2       = prev_key[63:32]  ^ n1;
        n3       = prev_key[31:0]   ^ n2;
    end

    // Next-state, table-write and status decisions for the IDLE/EXPAND sequencer.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        busy_n       = busy_o;
        done_n       = 1'b0;
        keys_valid_n = keys_valid_o;
        wr_en        = 1'b0;
        wr_idx       = cnt;
        wr_data      = {n0, n1, n2, n3};
        case (state)
            IDLE: begin
                if (start_i) begin
                    wr_en        = 1'b1;
                    wr_idx       = 4'd0;
                    wr_data      = key_i;
                    cnt_n        = 4'd1;
                    keys_valid_n = 1'b0;
                    busy_n       = 1'b1;
                    state_n      = EXPAND;
                end
            end
            EXPAND: begin
                wr_en = 1'b1;
                cnt_n = cnt + 4'd1;
                if (cnt == LAST) begin
                    cnt_n        = 4'd0;
                    busy_n       = 1'b0;
                    done_n       = 1'b1;
                    keys_valid_n = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sequencer state and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            keys_valid_o <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
            keys_valid_o <= keys_valid_n;
        end
    end

    // Round-key table; a reset wipes every entry so no partial key set survives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_tab[i] <= 128'h0;
        end else if (wr_en) begin
            rk_tab[wr_idx] <= wr_data;
        end
    end

    // Decryption reads the table back to front so the consumer always counts upward.
    always_comb begin
        rd_e = enc_or_dec_i ? rk_idx_i : (LAST - rk_idx_i);
    end

    // Registered read port; a same-edge write is not forwarded, so the old entry is returned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rk_o <= 128'h0;
        end else if (rk_idx_i > LAST) begin
            rk_o <= 128'h0;
        end else begin
            rk_o <= rk_tab[rd_e];
        end
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. Expands one 128-bit cipher key into the 11 round keys RK0..RK10 at one round key per clock.
- Holds the round keys in an internal register file.
- Sits directly upstream of the per-round datapath: its registered read port drives that datapath's 128-bit round-key input.
- Read order is forward for encryption and reversed for decryption, so the round sequencer always counts its read index upward from 0.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; fixed at 10 for AES-128; other values unsupported.

Ports:
clk_i  input  1  single clock; all state updates on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
start_i  input  1  request a new expansion; sampled only in IDLE.
key_i  input  128  cipher key; key_i[127:120] is key byte 0; sampled on the accepting edge only.
enc_or_dec_i  input  1  1 = encryption read order, 0 = decryption read order.
rk_idx_i  input  4  round-key read index, 0..10.
rk_o  output  128  registered round key selected by rk_idx_i and enc_or_dec_i.
busy_o  output  1  high while expansion is in progress.
done_o  output  1  one-cycle pulse when RK10 has been written.
keys_valid_o  output  1  high while the table holds a complete key set.

Behaviour:
- Reset (async, rst_i=1):
  - State = IDLE, round counter = 0.
  - All 11 table entries = 0.
  - rk_o = 0, busy_o = 0, done_o = 0, keys_valid_o = 0.
  - Reset mid-expansion aborts the expansion; no partial keys remain valid.
- States:
  - IDLE: on start_i=1 at edge T:
    - RK0 <= key_i, counter <= 1.
    - keys_valid_o <= 0, busy_o <= 1, go to EXPAND.
  - EXPAND: each edge writes RK[counter] from RK[counter-1], then counter++.
    - The edge writing RK10 (T+10) also sets busy_o <= 0, done_o <= 1, keys_valid_o <= 1, and returns to IDLE.
- Timing:
  - busy_o is high for exactly 10 cycles (edges T+1..T+10).
  - done_o is high for exactly the cycle following edge T+10; it clears on the next edge.
- Round step, with previous key words w0..w3 (w0 = bits [127:96]):
  - RotWord(w3) = {w3[23:0], w3[31:24]}.
  - SubWord applies the forward AES S-box to each byte.
  - t = SubWord(RotWord(w3)) XOR {Rcon, 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
  - The S-box is a 256-entry combinational table inside this block; four instances, one per byte.
- Start handling:
  - start_i while busy_o=1 is ignored; key_i is not re-sampled.
  - start_i during the done_o cycle is accepted as a new IDLE start: keys_valid_o falls at that edge.
- Read port, one-cycle latency:
  - At every edge, rk_o <= table[e], where e = rk_idx_i if enc_or_dec_i=1, else e = 10 - rk_idx_i.
  - rk_idx_i > 10 gives rk_o <= 0.
  - Reads during EXPAND return current table contents, which may be stale or partial. Consumers must gate on keys_valid_o.
  - A read of index e in the same cycle that entry e is written returns the old value.

Test Plan:
- Reset check: assert rst_i asynchronously, mid-cycle -> immediately rk_o=0, busy_o=0, done_o=0, keys_valid_o=0.
- FIPS-197 expansion: key_i=2b7e151628aed2a6abf7158809cf4f3c, start_i for 1 cycle.
  - busy_o high for exactly 10 cycles; done_o a single pulse; keys_valid_o then 1.
  - enc_or_dec_i=1: rk_idx_i=0 gives 2b7e1516...09cf4f3c; 1 gives a0fafe1788542cb123a339392a6c7605; 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6, each one cycle after the index is applied.
- Decryption ordering: after the same expansion, enc_or_dec_i=0, rk_idx_i=0 -> rk_o=d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx_i=10 -> rk_o=2b7e151628aed2a6abf7158809cf4f3c.
- Start while busy and out-of-range index:
  - Pulse start_i with key_i=0 at cycle 4 of an expansion -> ignored; the table ends with the FIPS-197 keys.
  - rk_idx_i=15 -> rk_o=0.
- Back-to-back start: start_i=1 with key_i=0 during the done_o cycle.
  - keys_valid_o falls at that edge; after 10 more cycles RK1 = 62636363626363636263636362636363.
- Reset mid-expansion: assert rst_i at busy cycle 5 -> busy_o=0, keys_valid_o=0, all entries read 0; a new start_i afterwards completes normally.
